// File: rtl/rt_terminal.sv
// rt_terminal -- MKIO (GOST R 52070) remote-terminal responder.
// Decodes command words, serves transmit (RAM -> bus) and receive (bus -> RAM)
// messages over 2^SA_BITS subaddress buffers of 32 words each, with a host port
// into the buffer RAM, a receive-gap timeout and message-error reporting.
// Optional feature: define RT_BROADCAST_EN to accept RTA=31 broadcast receive
// commands (no status reply, "broadcast received" flagged in the next status).
module rt_terminal #(
    parameter logic [4:0] ADDRESS        = 5'd1,
    parameter int         SA_BITS        = 2,
    parameter int         PAUSE_CYCLES   = 256,
    parameter int         READY_CYCLES   = 3,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic                 rx_valid,
    input  logic [15:0]          rx_data,
    input  logic                 p_error,
    output logic [15:0]          tx_data,
    output logic                 tx_cd,
    output logic                 tx_ready,
    input  logic                 tx_busy,
    input  logic                 host_we,
    input  logic [SA_BITS+4:0]   host_addr,
    input  logic [15:0]          host_wdata,
    output logic [15:0]          host_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 msg_err
);

    localparam int AW      = SA_BITS + 5;
    localparam int DEPTH   = 32 << SA_BITS;
    localparam int CNT_MAX = (PAUSE_CYCLES > READY_CYCLES) ? PAUSE_CYCLES : READY_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_RX_DATA   = 4'd2;
    localparam logic [3:0] S_PAUSE     = 4'd3;
    localparam logic [3:0] S_LOAD_SW   = 4'd4;
    localparam logic [3:0] S_WAIT_TX   = 4'd5;
    localparam logic [3:0] S_SEND      = 4'd6;
    localparam logic [3:0] S_READ      = 4'd7;
    localparam logic [3:0] S_READ_WAIT = 4'd8;
    localparam logic [3:0] S_LOAD_DW   = 4'd9;
    localparam logic [3:0] S_DONE      = 4'd10;

    logic [3:0]         r_state;
    logic               r_tr;
    logic [SA_BITS-1:0] r_sa;
    logic               r_sa_ok;
    logic [5:0]         r_n;
    logic [5:0]         r_idx;
    logic               r_merr;
    logic               r_bcast;
    logic               r_bcast_pend;
    logic [CW-1:0]      r_cnt;
    logic [TW-1:0]      r_tmo;
    logic [15:0]        r_tx_data;
    logic               r_tx_cd;
    logic               r_tx_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_msg_err;
    logic [15:0]        r_host_rdata;
    logic [AW-1:0]      r_rd_addr;
    logic [15:0]        r_ram_q;
    logic [15:0]        r_mem [0:DEPTH-1];

    logic               w_is_bcast;
    logic               w_accept;
    logic               w_sa_ok;
    logic [5:0]         w_cmd_n;
    logic [5:0]         w_idx_next;
    logic               w_core_we;
    logic [AW-1:0]      w_core_addr;
    logic [15:0]        w_status;

`ifdef RT_BROADCAST_EN
    assign w_is_bcast = (rx_data[15:11] == 5'd31) && !rx_data[10];
    assign w_accept   = cmd_valid && ((rx_data[15:11] == ADDRESS) || w_is_bcast);
`else
    assign w_is_bcast = 1'b0;
    assign w_accept   = cmd_valid && (rx_data[15:11] == ADDRESS);
`endif

    assign w_sa_ok     = (32'(rx_data[9:5]) < (32'd1 << SA_BITS));
    assign w_cmd_n     = (rx_data[4:0] == 5'd0) ? 6'd32 : {1'b0, rx_data[4:0]};
    assign w_idx_next  = r_idx + 6'd1;
    assign w_core_addr = {r_sa, r_idx[4:0]};
    assign w_status    = {ADDRESS, r_merr, 5'd0, r_bcast_pend, 4'd0};
    // Out-of-range subaddresses are flagged as message errors and never written,
    // so they cannot alias onto another buffer.
    assign w_core_we   = (r_state == S_RX_DATA) && rx_valid && r_sa_ok && !w_accept;

    // Command decode, message sequencing and transmit-side output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tr         <= 1'b0;
            r_sa         <= '0;
            r_sa_ok      <= 1'b0;
            r_n          <= '0;
            r_idx        <= '0;
            r_merr       <= 1'b0;
            r_bcast      <= 1'b0;
            r_bcast_pend <= 1'b0;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_tx_data    <= '0;
            r_tx_cd      <= 1'b0;
            r_tx_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_msg_err    <= 1'b0;
            r_rd_addr    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_state    <= S_DECODE;
                r_busy     <= 1'b1;
                r_tx_ready <= 1'b0;
                r_tr       <= rx_data[10];
                r_sa       <= rx_data[5 +: SA_BITS];
                r_sa_ok    <= w_sa_ok;
                r_n        <= w_cmd_n;
                r_merr     <= p_error | ~w_sa_ok;
                r_bcast    <= w_is_bcast;
                r_idx      <= '0;
                r_cnt      <= '0;
                r_tmo      <= '0;
            end else begin
                case (r_state)
                    S_DECODE: begin
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_tmo   <= '0;
                        r_state <= r_tr ? S_PAUSE : S_RX_DATA;
                    end
                    S_RX_DATA: begin
                        if (rx_valid) begin
                            r_merr <= r_merr | p_error;
                            r_idx  <= w_idx_next;
                            r_tmo  <= '0;
                            if (w_idx_next == r_n) begin
                                if (r_bcast) begin
                                    r_state      <= S_DONE;
                                    r_done       <= 1'b1;
                                    r_busy       <= 1'b0;
                                    r_bcast_pend <= 1'b1;
                                end else begin
                                    r_state <= S_PAUSE;
                                    r_cnt   <= '0;
                                end
                            end
                        end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_tmo <= r_tmo + TW'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (r_cnt == CW'(PAUSE_CYCLES - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_LOAD_SW;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_LOAD_SW: begin
                        r_tx_data    <= w_status;
                        r_tx_cd      <= 1'b0;
                        r_msg_err    <= r_merr;
                        r_bcast_pend <= 1'b0;
                        r_state      <= S_WAIT_TX;
                    end
                    S_WAIT_TX: begin
                        if (!tx_busy) begin
                            r_tx_ready <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        if (r_cnt == CW'(READY_CYCLES - 1)) begin
                            r_tx_ready <= 1'b0;
                            r_cnt      <= '0;
                            // tx_cd tells whether the word just sent was the status word.
                            if (!r_tx_cd) begin
                                if (!r_tr || r_merr) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_state <= S_READ;
                                end
                            end else begin
                                r_idx <= w_idx_next;
                                if (w_idx_next == r_n) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_state <= S_READ;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_READ: begin
                        r_rd_addr <= w_core_addr;
                        r_state   <= S_READ_WAIT;
                    end
                    S_READ_WAIT: begin
                        r_state <= S_LOAD_DW;
                    end
                    S_LOAD_DW: begin
                        r_tx_data <= r_ram_q;
                        r_tx_cd   <= 1'b1;
                        r_state   <= S_WAIT_TX;
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Buffer RAM: core receive writes win over host writes; registered core read.
    always_ff @(posedge clk) begin
        if (w_core_we) begin
            r_mem[w_core_addr] <= rx_data;
        end else if (host_we) begin
            r_mem[host_addr] <= host_wdata;
        end
        r_ram_q <= r_mem[r_rd_addr];
    end

    // Host read port, one cycle latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_rdata <= '0;
        end else begin
            r_host_rdata <= r_mem[host_addr];
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_cd      = r_tx_cd;
    assign tx_ready   = r_tx_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign msg_err    = r_msg_err;
    assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_rt_terminal.sv
// Self-checking bench for rt_terminal: directed message sequence with random
// buffer contents and gaps, checked against a word-level reference model.
`timescale 1ns/1ps
module tb_rt_terminal;
    localparam logic [4:0] ADDR = 5'd1;
    localparam int SAB = 2;
    localparam int P   = 20;
    localparam int R   = 3;
    localparam int T   = 100;
    localparam int AW  = SAB + 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          rx_valid;
    logic [15:0]   rx_data;
    logic          p_error;
    logic [15:0]   tx_data;
    logic          tx_cd;
    logic          tx_ready;
    logic          tx_busy;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [15:0]   host_wdata;
    logic [15:0]   host_rdata;
    logic          busy;
    logic          done;
    logic          msg_err;

    rt_terminal #(
        .ADDRESS(ADDR), .SA_BITS(SAB), .PAUSE_CYCLES(P),
        .READY_CYCLES(R), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .rx_valid(rx_valid),
        .rx_data(rx_data), .p_error(p_error), .tx_data(tx_data), .tx_cd(tx_cd),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .busy(busy), .done(done), .msg_err(msg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference buffer contents, indexed {sa, word}.
    logic [15:0] mem_m [0:127];

    // Transmit-side observation: one entry per tx_ready rising edge.
    int          rise_cyc[$];
    logic [15:0] rise_data[$];
    logic        rise_cd[$];
    logic        rise_stable[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_cd = 1'b0;

    always @(negedge clk) begin
        if (tx_ready && !prev_ready) begin
            rise_cyc.push_back(cyc);
            rise_data.push_back(tx_data);
            rise_cd.push_back(tx_cd);
            rise_stable.push_back((tx_data === prev_data) && (tx_cd === prev_cd));
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        prev_ready = tx_ready;
        prev_data  = tx_data;
        prev_cd    = tx_cd;
    end

    function automatic logic [15:0] sw(input logic m, input logic b);
        return {ADDR, m, 5'd0, b, 4'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        rise_cyc.delete();
        rise_data.delete();
        rise_cd.delete();
        rise_stable.delete();
        done_cnt = 0;
    endtask

    task automatic send_cmd(input logic [15:0] w, input logic pe, output int c0);
        cmd_valid = 1'b1;
        rx_data   = w;
        p_error   = pe;
        c0        = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        p_error   = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic pe, output int wc);
        rx_valid = 1'b1;
        rx_data  = d;
        p_error  = pe;
        wc       = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        p_error  = 1'b0;
    endtask

    task automatic host_read(input int a, output logic [15:0] d);
        host_addr = AW'(a);
        @(negedge clk);
        d = host_rdata;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int k;
        k = 0;
        while (done_cnt == 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({tag, " done_seen"}, 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " tx_data"}, 32'(tx_data), 32'd0);
        check({tag, " tx_cd"}, 32'(tx_cd), 32'd0);
        check({tag, " tx_ready"}, 32'(tx_ready), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " msg_err"}, 32'(msg_err), 32'd0);
        check({tag, " host_rdata"}, 32'(host_rdata), 32'd0);
    endtask

    // Transmit message: status word after P+4 cycles, then N data words R+4 apart.
    task automatic run_tx(input int sa, input int n, input logic cpe, input logic bc, input string tag);
        int c0, nn, exp_rises;
        logic m;
        nn = (n == 0) ? 32 : n;
        m  = cpe || (sa >= 4);
        exp_rises = m ? 1 : nn + 1;
        clear_mon();
        send_cmd({ADDR, 1'b1, 5'(sa), 5'(n)}, cpe, c0);
        wait_done(P + 10 * (nn + 2), tag);
        tick(2);
        check({tag, " rises"}, rise_cyc.size(), exp_rises);
        if (rise_cyc.size() == exp_rises) begin
            check({tag, " sw"}, 32'(rise_data[0]), 32'(sw(m, bc)));
            check({tag, " sw_cd"}, 32'(rise_cd[0]), 32'd0);
            check({tag, " sw_cyc"}, rise_cyc[0], c0 + P + 4);
            check({tag, " sw_stable"}, 32'(rise_stable[0]), 32'd1);
            for (int i = 1; i < exp_rises; i++) begin
                check({tag, " dw"}, 32'(rise_data[i]), 32'(mem_m[sa * 32 + i - 1]));
                check({tag, " dw_cd"}, 32'(rise_cd[i]), 32'd1);
                check({tag, " dw_cyc"}, rise_cyc[i], rise_cyc[i - 1] + R + 4);
                check({tag, " dw_stable"}, 32'(rise_stable[i]), 32'd1);
            end
            check({tag, " done_cyc"}, done_cyc, rise_cyc[exp_rises - 1] + R);
        end
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " msg_err"}, 32'(msg_err), 32'(m));
    endtask

    // Receive message: words stored in the model, status P+3 cycles after the last word.
    task automatic run_rx(input int sa, input int n, input int perr_at, input logic use_base,
                          input logic [15:0] base, input string tag);
        int c0, wc, nn;
        logic [15:0] d;
        logic m;
        nn = (n == 0) ? 32 : n;
        m  = 1'b0;
        wc = 0;
        clear_mon();
        send_cmd({ADDR, 1'b0, 5'(sa), 5'(n)}, 1'b0, c0);
        for (int i = 0; i < nn; i++) begin
            tick($urandom_range(2, 8));
            d = use_base ? base + 16'(i) : 16'($urandom);
            if (i == 5) begin
                // Colliding host write to the same location must lose.
                host_we    = 1'b1;
                host_addr  = AW'(sa * 32 + i);
                host_wdata = ~d;
            end
            send_word(d, (i == perr_at), wc);
            host_we = 1'b0;
            mem_m[sa * 32 + i] = d;
            if (i == perr_at) m = 1'b1;
        end
        wait_done(P + 20, tag);
        tick(2);
        check({tag, " rises"}, rise_cyc.size(), 1);
        if (rise_cyc.size() == 1) begin
            check({tag, " sw"}, 32'(rise_data[0]), 32'(sw(m, 1'b0)));
            check({tag, " sw_cd"}, 32'(rise_cd[0]), 32'd0);
            check({tag, " sw_cyc"}, rise_cyc[0], wc + P + 3);
            check({tag, " done_cyc"}, done_cyc, rise_cyc[0] + R);
        end
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " msg_err"}, 32'(msg_err), 32'(m));
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, cx, wc, b, k;
        logic [15:0] d;

        reset = 1'b1; cmd_valid = 1'b0; rx_valid = 1'b0; rx_data = '0; p_error = 1'b0;
        tx_busy = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        tick(3);
        check_idle_outputs("reset");
        reset = 1'b0;
        tick(2);

        // Fill every buffer; SA1 words 0..3 get the fixed 0xA000+k pattern.
        for (int a = 0; a < 128; a++) begin
            d = (a >= 32 && a < 36) ? 16'hA000 + 16'(a - 32) : 16'($urandom);
            mem_m[a]   = d;
            host_we    = 1'b1;
            host_addr  = AW'(a);
            host_wdata = d;
            tick(1);
        end
        host_we = 1'b0;
        for (int j = 0; j < 4; j++) begin
            k = $urandom_range(0, 127);
            host_read(k, d);
            check("host_readback", 32'(d), 32'(mem_m[k]));
        end

        run_tx(1, 3, 1'b0, 1'b0, "tp_tx_0C23");
        for (int j = 0; j < 3; j++) begin
            run_tx($urandom_range(0, 3), $urandom_range(1, 6), 1'b0, 1'b0, "rand_tx");
        end
        run_tx(0, 0, 1'b0, 1'b0, "tx_n32");
        run_tx(1, 2, 1'b1, 1'b0, "tx_cmd_perr");
        run_tx(5, 2, 1'b0, 1'b0, "tx_sa_range");

        // Status word held back while the channel reports busy.
        clear_mon();
        tx_busy = 1'b1;
        send_cmd(16'h0C21, 1'b0, c0);
        tick(P + 10);
        b = cyc;
        tx_busy = 1'b0;
        wait_done(P + 40, "stall");
        tick(2);
        check("stall rises", rise_cyc.size(), 2);
        if (rise_cyc.size() == 2) begin
            check("stall sw_cyc", rise_cyc[0], b + 1);
            check("stall sw", 32'(rise_data[0]), 32'(sw(1'b0, 1'b0)));
            check("stall dw", 32'(rise_data[1]), 32'(mem_m[32]));
        end

        run_rx(2, 0, -1, 1'b1, 16'h5500, "tp_rx_0840");
        host_read(2 * 32 + 31, d);
        check("host_rd_2_31", 32'(d), 32'h551F);
        host_read(2 * 32 + 5, d);
        check("host_rd_core_wins", 32'(d), 32'h5505);

        run_rx(3, 2, 1, 1'b0, 16'h0000, "rx_perr");
        host_read(3 * 32 + 1, d);
        check("rx_perr stored", 32'(d), 32'(mem_m[3 * 32 + 1]));
        run_rx($urandom_range(0, 3), $urandom_range(1, 8), -1, 1'b0, 16'h0000, "rand_rx");
        run_tx(3, 2, 1'b0, 1'b0, "tx_after_rx");

        // Receive timeout: 2 of 4 words, then silence.
        clear_mon();
        send_cmd({ADDR, 1'b0, 5'd3, 5'd4}, 1'b0, c0);
        tick(3);
        send_word(16'($urandom), 1'b0, wc);
        tick(3);
        send_word(16'($urandom), 1'b0, wc);
        tick(T - 3);
        check("timeout busy_before", 32'(busy), 32'd1);
        tick(5);
        check("timeout busy_after", 32'(busy), 32'd0);
        tick(P + 20);
        check("timeout rises", rise_cyc.size(), 0);
        check("timeout done", done_cnt, 0);
        check("timeout tx_ready", 32'(tx_ready), 32'd0);

        // Abort during SEND of data word 2, then an ignored foreign command.
        clear_mon();
        send_cmd(16'h0C23, 1'b0, c0);
        k = 0;
        while (rise_cyc.size() < 3 && k < P + 60) begin
            @(negedge clk);
            k++;
        end
        check("abort reached_dw2", 32'(rise_cyc.size() >= 3), 32'd1);
        send_cmd(16'h0C22, 1'b0, c1);
        tick(4);
        send_cmd(16'h2C23, 1'b0, cx);
        wait_done(P + 60, "abort");
        tick(2);
        check("abort rises", rise_cyc.size(), 6);
        if (rise_cyc.size() == 6) begin
            check("abort dw2", 32'(rise_data[2]), 32'h0000A001);
            check("abort restart_cyc", rise_cyc[3], c1 + P + 4);
            check("abort restart_sw", 32'(rise_data[3]), 32'(sw(1'b0, 1'b0)));
            check("abort dw_a", 32'(rise_data[4]), 32'(mem_m[32]));
            check("abort dw_b", 32'(rise_data[5]), 32'(mem_m[33]));
            check("abort dw_cyc", rise_cyc[5], rise_cyc[4] + R + 4);
        end
        check("abort done_cnt", done_cnt, 1);

        // Foreign terminal addresses are ignored.
        for (int j = 0; j < 3; j++) begin
            clear_mon();
            send_cmd({5'($urandom_range(2, 30)), 1'($urandom), 5'd1, 5'd2}, 1'b0, cx);
            tick(2);
            check("foreign busy", 32'(busy), 32'd0);
            tick(P + 10);
            check("foreign rises", rise_cyc.size(), 0);
            check("foreign done", done_cnt, 0);
        end

`ifdef RT_BROADCAST_EN
        clear_mon();
        send_cmd(16'hF821, 1'b0, c0);
        tick(3);
        d = 16'($urandom);
        send_word(d, 1'b0, wc);
        mem_m[32] = d;
        wait_done(10, "bcast");
        tick(P + 20);
        check("bcast rises", rise_cyc.size(), 0);
        check("bcast done_cyc", done_cyc, wc + 1);
        check("bcast busy", 32'(busy), 32'd0);
        run_tx(1, 1, 1'b0, 1'b1, "bcast_flag");
        run_tx(1, 1, 1'b0, 1'b0, "bcast_clear");
        clear_mon();
        send_cmd(16'hFC21, 1'b0, cx);
        tick(P + 20);
        check("bcast_tx rises", rise_cyc.size(), 0);
        check("bcast_tx done", done_cnt, 0);
        check("bcast_tx busy", 32'(busy), 32'd0);
`else
        clear_mon();
        send_cmd(16'hF821, 1'b0, c0);
        tick(3);
        send_word(16'($urandom), 1'b0, wc);
        tick(P + 20);
        check("rta31 rises", rise_cyc.size(), 0);
        check("rta31 done", done_cnt, 0);
        check("rta31 busy", 32'(busy), 32'd0);
        run_tx(1, 1, 1'b0, 1'b0, "rta31_after");
`endif

        // Reset in the middle of the status-word SEND.
        clear_mon();
        send_cmd(16'h0C21, 1'b0, c0);
        k = 0;
        while (rise_cyc.size() < 1 && k < P + 20) begin
            @(negedge clk);
            k++;
        end
        check("midreset reached_send", 32'(tx_ready), 32'd1);
        reset = 1'b1;
        tick(1);
        check_idle_outputs("midreset");
        reset = 1'b0;
        tick(P + 30);
        check("midreset rises", rise_cyc.size(), 1);
        check("midreset done", done_cnt, 0);
        check("midreset busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
